// File: rtl/store_check_pkg.sv
// Shared types for the store sequence checker: run-state encoding and the
// status codes reported on fail_code.
package store_check_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store table: NUM_CHECKS entries of {address, data}.
// Synchronous write port, combinational read port, asynchronous active-low
// clear. Out-of-range write indices are dropped; out-of-range reads return 0.
module store_exp_table #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W:0]    rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_CHECKS);

    logic [ADDR_W-1:0] addr_q [NUM_CHECKS];
    logic [DATA_W-1:0] data_q [NUM_CHECKS];

    // Entry storage: cleared on reset, written one entry per enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_idx} < NUM_L)) begin
            addr_q[wr_idx] <= wr_addr;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Read of the entry currently being waited for; 0 once past the end.
    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        if (rd_idx < NUM_L) begin
            rd_addr = addr_q[rd_idx[IDX_W-1:0]];
            rd_data = data_q[rd_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/store_sequence_checker.sv
// Store sequence checker: watches the data-memory write port and compares
// stores against a programmable table of expected {address, data} pairs,
// with a cycle timeout. Optional capture of the offending store is enabled
// by defining STORE_CHECK_CAPTURE_EN.
//
// Store bus: mem_write acts as a valid strobe with no back-pressure; every
// cycle with mem_write=1 in RUN is one observed store, consumed that cycle.
module store_sequence_checker
    import store_check_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ORDERED        = 1,
    localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CYC_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W:0]    exp_count,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W:0]    match_count,
    output logic [CYC_W-1:0]  cycle_count,
`ifdef STORE_CHECK_CAPTURE_EN
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [IDX_W-1:0]  fail_idx,
`endif
    output state_t            dbg_state
);

    localparam logic [IDX_W:0]   NUM_L  = (IDX_W + 1)'(NUM_CHECKS);
    localparam logic [CYC_W-1:0] T_MAX  = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [CYC_W-1:0] T_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [IDX_W:0]    match_q, match_d;
    logic [CYC_W-1:0]  cycle_q, cycle_d;
    logic [1:0]        fc_q, fc_d;
`ifdef STORE_CHECK_CAPTURE_EN
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
`endif

    logic              tbl_we;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;
    logic [IDX_W:0]    count_clamped;
    logic [IDX_W:0]    match_inc;
    logic              addr_hit;
    logic              data_hit;
    logic              run_done;

    store_exp_table #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tbl_we),
        .wr_idx  (exp_idx),
        .wr_addr (exp_addr),
        .wr_data (exp_data),
        .rd_idx  (match_q),
        .rd_addr (tbl_addr),
        .rd_data (tbl_data)
    );

    assign count_clamped = (exp_count > NUM_L) ? NUM_L : exp_count;
    assign match_inc     = match_q + 1'b1;
    assign addr_hit      = (data_adr == tbl_addr);
    assign data_hit      = (write_data == tbl_data);

    // Next-state logic: table load and arming outside RUN, store matching and
    // timeout inside RUN. A deciding store takes priority over the timeout.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        match_d    = match_q;
        cycle_d    = cycle_q;
        fc_d       = fc_q;
`ifdef STORE_CHECK_CAPTURE_EN
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_idx_d  = cap_idx_q;
`endif
        tbl_we     = 1'b0;
        run_done   = 1'b0;

        case (state_q)
            RUN: begin
                // cycle_count counts every RUN cycle, including the deciding one.
                cycle_d = (cycle_q == T_MAX) ? cycle_q : cycle_q + 1'b1;
                if (mem_write) begin
                    if (addr_hit && data_hit) begin
                        match_d = match_inc;
                        if (match_inc == count_q) begin
                            state_d  = PASS;
                            run_done = 1'b1;
                        end
                    end else if ((ORDERED != 0) || addr_hit) begin
                        state_d    = FAIL;
                        fc_d       = FC_MISMATCH;
                        run_done   = 1'b1;
`ifdef STORE_CHECK_CAPTURE_EN
                        cap_addr_d = data_adr;
                        cap_data_d = write_data;
                        cap_idx_d  = match_q[IDX_W-1:0];
`endif
                    end
                end
                if (!run_done && (cycle_q == T_LAST)) begin
                    state_d = TIMEOUT;
                    fc_d    = FC_TIMEOUT;
                end
            end
            default: begin
                tbl_we = exp_we;
                if (start) begin
                    count_d    = count_clamped;
                    match_d    = '0;
                    cycle_d    = '0;
                    fc_d       = FC_NONE;
`ifdef STORE_CHECK_CAPTURE_EN
                    cap_addr_d = '0;
                    cap_data_d = '0;
                    cap_idx_d  = '0;
`endif
                    state_d    = (count_clamped == '0) ? PASS : RUN;
                end
            end
        endcase
    end

    // State and status registers; reset aborts any run without a report.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            match_q    <= '0;
            cycle_q    <= '0;
            fc_q       <= FC_NONE;
`ifdef STORE_CHECK_CAPTURE_EN
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_idx_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            match_q    <= match_d;
            cycle_q    <= cycle_d;
            fc_q       <= fc_d;
`ifdef STORE_CHECK_CAPTURE_EN
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_idx_q  <= cap_idx_d;
`endif
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == PASS) || (state_q == FAIL) || (state_q == TIMEOUT);
    assign pass        = (state_q == PASS);
    assign fail_code   = fc_q;
    assign match_count = match_q;
    assign cycle_count = cycle_q;
    assign dbg_state   = state_q;
`ifdef STORE_CHECK_CAPTURE_EN
    assign fail_addr   = cap_addr_q;
    assign fail_data   = cap_data_q;
    assign fail_idx    = cap_idx_q;
`endif

endmodule

// File: tb/tb_store_sequence_checker.sv
// Bench for store_sequence_checker: one ordered and one unordered instance
// share the same stimulus. A cycle table drives the basic pass / ordered
// mismatch / zero-count flow; hand-written sequences cover filtering,
// timeout ties, clamping, writes while busy and asynchronous reset.
module tb_store_sequence_checker;
    import store_check_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int TO = 16;
    localparam int IW = 3;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW:0]   exp_count;
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          mem_write;
    logic [AW-1:0] data_adr;
    logic [DW-1:0] write_data;

    logic          o_busy, o_done, o_pass, u_busy, u_done, u_pass;
    logic [1:0]    o_fc, u_fc;
    logic [IW:0]   o_mc, u_mc;
    logic [CW-1:0] o_cyc, u_cyc;
    state_t        o_st, u_st;
`ifdef STORE_CHECK_CAPTURE_EN
    logic [AW-1:0] o_fa, u_fa;
    logic [DW-1:0] o_fd, u_fd;
    logic [IW-1:0] o_fi, u_fi;
`endif

    int tests = 0;
    int fails = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    store_sequence_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .ORDERED(1)
    ) u_ord (
        .clk(clk), .reset(reset), .start(start), .exp_count(exp_count),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .busy(o_busy), .done(o_done), .pass(o_pass), .fail_code(o_fc),
        .match_count(o_mc), .cycle_count(o_cyc),
`ifdef STORE_CHECK_CAPTURE_EN
        .fail_addr(o_fa), .fail_data(o_fd), .fail_idx(o_fi),
`endif
        .dbg_state(o_st)
    );

    store_sequence_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO), .ORDERED(0)
    ) u_uno (
        .clk(clk), .reset(reset), .start(start), .exp_count(exp_count),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
        .busy(u_busy), .done(u_done), .pass(u_pass), .fail_code(u_fc),
        .match_count(u_mc), .cycle_count(u_cyc),
`ifdef STORE_CHECK_CAPTURE_EN
        .fail_addr(u_fa), .fail_data(u_fd), .fail_idx(u_fi),
`endif
        .dbg_state(u_st)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          start;
        logic [IW:0]   cnt;
        logic          we;
        logic [IW-1:0] idx;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_data;
        logic          mw;
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
        logic          e_busy;
        logic          e_done;
        logic          e_pass;
        logic [1:0]    e_fc;
        logic [IW:0]   e_mc;
        logic [CW-1:0] e_cyc;
    } vec_t;

    vec_t vecs[$];

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        start      = 1'b0;
        exp_count  = '0;
        exp_we     = 1'b0;
        exp_idx    = '0;
        exp_addr   = '0;
        exp_data   = '0;
        mem_write  = 1'b0;
        data_adr   = '0;
        write_data = '0;
    endtask

    task automatic do_reset();
        bus_idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic load(input int idx, input int a, input int d);
        exp_we   = 1'b1;
        exp_idx  = IW'(idx);
        exp_addr = AW'(a);
        exp_data = DW'(d);
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic begin_run(input int c);
        start     = 1'b1;
        exp_count = (IW + 1)'(c);
        tick();
        start     = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        mem_write  = 1'b1;
        data_adr   = AW'(a);
        write_data = DW'(d);
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic add_vec(input logic st, input int cnt, input logic we, input int idx,
                           input int ta, input int td, input logic mw, input int a, input int d,
                           input logic eb, input logic ed, input logic ep, input int efc,
                           input int emc, input int ecyc);
        vec_t v;
        v.start = st;   v.cnt = (IW + 1)'(cnt);
        v.we = we;      v.idx = IW'(idx);  v.t_addr = AW'(ta);  v.t_data = DW'(td);
        v.mw = mw;      v.adr = AW'(a);    v.wd = DW'(d);
        v.e_busy = eb;  v.e_done = ed;     v.e_pass = ep;
        v.e_fc = 2'(efc); v.e_mc = (IW + 1)'(emc); v.e_cyc = CW'(ecyc);
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: st cnt we idx taddr tdata mw adr wd | busy done pass fc mc cyc
        add_vec(0, 0, 1, 0, 100, 25, 0,   0,  0,   0, 0, 0, 0, 0, 0); // load entry 0
        add_vec(1, 1, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 0); // start, count 1
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 2);
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 3);
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 4);
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 5);
        add_vec(0, 0, 0, 0,   0,  0, 1, 100, 25,   0, 1, 1, 0, 1, 6); // store at cycle 5
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   0, 1, 1, 0, 1, 6); // PASS holds
        add_vec(0, 0, 0, 0,   0,  0, 1,   5,  5,   0, 1, 1, 0, 1, 6); // store ignored
        add_vec(0, 0, 1, 1, 104,  7, 0,   0,  0,   0, 1, 1, 0, 1, 6); // load entry 1
        add_vec(1, 2, 0, 0,   0,  0, 0,   0,  0,   1, 0, 0, 0, 0, 0); // start, count 2
        add_vec(0, 0, 0, 0,   0,  0, 1, 100, 25,   1, 0, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0,   0,  0, 1,  96,  7,   0, 1, 0, 1, 1, 2); // ordered mismatch
        add_vec(0, 0, 0, 0,   0,  0, 0,   0,  0,   0, 1, 0, 1, 1, 2); // FAIL holds
        add_vec(1, 0, 0, 0,   0,  0, 0,   0,  0,   0, 1, 1, 0, 0, 0); // count 0 -> PASS

        // ---------------- reset state ----------------
        bus_idle();
        reset = 1'b0;
        repeat (2) tick();
        check("rst busy", o_busy, 0);
        check("rst done", o_done, 0);
        check("rst pass", o_pass, 0);
        check("rst fc", o_fc, 0);
        check("rst mc", o_mc, 0);
        check("rst cyc", o_cyc, 0);
        check("rst state", o_st, IDLE);
        check("rst uno done", u_done, 0);
        reset = 1'b1;

        // ---------------- table-driven flow (ordered instance) ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            start      = vecs[i].start;
            exp_count  = vecs[i].cnt;
            exp_we     = vecs[i].we;
            exp_idx    = vecs[i].idx;
            exp_addr   = vecs[i].t_addr;
            exp_data   = vecs[i].t_data;
            mem_write  = vecs[i].mw;
            data_adr   = vecs[i].adr;
            write_data = vecs[i].wd;
            tick();
            bus_idle();
            check($sformatf("vec%0d busy", i), o_busy, vecs[i].e_busy);
            check($sformatf("vec%0d done", i), o_done, vecs[i].e_done);
            check($sformatf("vec%0d pass", i), o_pass, vecs[i].e_pass);
            check($sformatf("vec%0d fc", i), o_fc, vecs[i].e_fc);
            check($sformatf("vec%0d mc", i), o_mc, vecs[i].e_mc);
            check($sformatf("vec%0d cyc", i), o_cyc, vecs[i].e_cyc);
`ifdef STORE_CHECK_CAPTURE_EN
            if (i == 13) begin
                check("ord cap addr", o_fa, 96);
                check("ord cap data", o_fd, 7);
                check("ord cap idx", o_fi, 1);
            end
`endif
        end

        // ---------------- unordered filtering -> PASS ----------------
        do_reset();
        load(0, 100, 25);
        load(1, 104, 7);
        begin_run(2);
        store(80, 1);
        check("uno filt busy", u_busy, 1);
        check("uno filt mc0", u_mc, 0);
        check("ord strict fc", o_fc, FC_MISMATCH);
        check("ord strict mc", o_mc, 0);
`ifdef STORE_CHECK_CAPTURE_EN
        check("ord cap addr0", o_fa, 80);
        check("ord cap idx0", o_fi, 0);
`endif
        store(100, 25);
        store(60, 3);
        check("uno mid mc", u_mc, 1);
        store(104, 7);
        check("uno pass", u_pass, 1);
        check("uno pass mc", u_mc, 2);
        check("uno pass fc", u_fc, FC_NONE);

        // ---------------- unordered data mismatch -> FAIL ----------------
        do_reset();
        load(0, 100, 25);
        load(1, 104, 7);
        begin_run(2);
        store(80, 1);
        store(100, 25);
        store(60, 3);
        store(104, 8);
        check("uno fail fc", u_fc, FC_MISMATCH);
        check("uno fail done", u_done, 1);
        check("uno fail pass", u_pass, 0);
        check("uno fail mc", u_mc, 1);
`ifdef STORE_CHECK_CAPTURE_EN
        check("uno cap addr", u_fa, 104);
        check("uno cap data", u_fd, 8);
        check("uno cap idx", u_fi, 1);
`endif

        // ---------------- timeout ----------------
        do_reset();
        load(0, 100, 25);
        begin_run(1);
        repeat (15) tick();
        check("to pre busy", o_busy, 1);
        check("to pre cyc", o_cyc, 15);
        tick();
        check("to fc", o_fc, FC_TIMEOUT);
        check("to done", o_done, 1);
        check("to pass", o_pass, 0);
        check("to busy", o_busy, 0);
        check("to state", o_st, TIMEOUT);
        check("to cyc", o_cyc, 16);
        check("to uno fc", u_fc, FC_TIMEOUT);
        repeat (3) tick();
        check("to hold cyc", o_cyc, 16);
        check("to hold fc", o_fc, FC_TIMEOUT);

        // ---------------- final match in timeout cycle ----------------
        do_reset();
        load(0, 100, 25);
        begin_run(1);
        repeat (15) tick();
        store(100, 25);
        check("tie pass", o_pass, 1);
        check("tie fc", o_fc, FC_NONE);
        check("tie mc", o_mc, 1);

        // ---------------- mismatch in timeout cycle ----------------
        do_reset();
        load(0, 100, 25);
        begin_run(1);
        repeat (15) tick();
        store(100, 26);
        check("tie mis fc", o_fc, FC_MISMATCH);
        check("tie mis uno fc", u_fc, FC_MISMATCH);

        // ---------------- clamp and write while busy ----------------
        do_reset();
        for (int i = 0; i < NC; i++) load(i, 200 + 4 * i, i + 1);
        begin_run(NC + 3);
        load(0, 999, 9);
        for (int i = 0; i < NC - 1; i++) store(200 + 4 * i, i + 1);
        check("clamp busy", o_busy, 1);
        check("clamp mc7", o_mc, 7);
        store(200 + 4 * (NC - 1), NC);
        check("clamp pass", o_pass, 1);
        check("clamp mc8", o_mc, NC);
        check("clamp uno pass", u_pass, 1);

        // ---------------- asynchronous reset mid-run ----------------
        do_reset();
        load(0, 100, 25);
        begin_run(1);
        repeat (2) tick();
        check("arst pre busy", o_busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst busy", o_busy, 0);
        check("arst cyc", o_cyc, 0);
        check("arst state", o_st, IDLE);
        tick();
        reset = 1'b1;
        begin_run(1);
        store(0, 0);
        check("arst table cleared", o_pass, 1);
        load(0, 100, 25);
        begin_run(1);
        store(100, 25);
        check("arst rerun pass", o_pass, 1);
        check("arst rerun mc", o_mc, 1);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
